// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    // Geometry of the attached single-port RAM.
    localparam int RAM_AW = 5;
    localparam int RAM_DW = 32;

    // Sequencer state encoding; the numeric values are part of the design.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RDATA = 3'd3,
        ACK   = 3'd4
    } state_t;

    // Requester identifiers as carried in the grant and last_gnt registers.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // True for the only state in which the arbiter may drive the RAM data bus.
    function automatic logic state_drives_bus(state_t s);
        return (s == WRITE);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner select: round-robin on last_gnt, or fixed priority when
// RAM_ARB_FIXED_PRI_EN is defined.
// Latency: purely combinational. Backpressure: none; losers simply keep req high.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_vld,
    output logic gnt_id
);

`ifdef RAM_ARB_FIXED_PRI_EN
    // Fixed priority ignores grant history, so requester 1 can starve.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    // Pick the winner among the live requests.
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = REQ_ID0;
`ifdef RAM_ARB_FIXED_PRI_EN
        if (!req0 && req1) begin
            gnt_id = REQ_ID1;
        end
`else
        if (req0 && req1) begin
            // Tie: whoever was not served last goes now.
            gnt_id = ~last_gnt;
        end else if (req1) begin
            gnt_id = REQ_ID1;
        end
`endif
    end

endmodule

// File: rtl/ram_arb2.sv
// Arbitrates CPU/DMA requests onto a 32-word single-port RAM and owns its
// tri-state data bus. Latency: write ack at N+2, read ack+rdata at N+3.
// Backpressure: a losing or late req waits high until its own ack; never dropped.
// Build option: RAM_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins ties).
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_ena,
    output logic          mem_wena,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);

    state_t        state;
    logic          last_gnt;
    logic          id_q;
    logic [DW-1:0] wdata_q;
    logic          drv_q;

    logic          gnt_vld;
    logic          gnt_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    // Fields of the winning requester, captured only in IDLE.
    assign sel_we    = gnt_id ? we1    : we0;
    assign sel_addr  = gnt_id ? addr1  : addr0;
    assign sel_wdata = gnt_id ? wdata1 : wdata0;

    // The RAM drives the bus whenever wena is low, so we release it outside WRITE.
    assign mem_data = drv_q ? wdata_q : {DW{1'bz}};

    // Sequencer with registered RAM controls, ack pulses and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= REQ_ID1;
            id_q     <= REQ_ID0;
            wdata_q  <= '0;
            drv_q    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            mem_ena  <= 1'b0;
            mem_wena <= 1'b0;
            mem_addr <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        id_q     <= gnt_id;
                        last_gnt <= gnt_id;
                        mem_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        busy     <= 1'b1;
                        mem_ena  <= 1'b1;
                        if (sel_we) begin
                            state    <= WRITE;
                            mem_wena <= 1'b1;
                            drv_q    <= state_drives_bus(WRITE);
                        end else begin
                            state    <= READ;
                            mem_wena <= 1'b0;
                            drv_q    <= state_drives_bus(READ);
                        end
                    end
                end
                WRITE: begin
                    // RAM commits the word on this edge; release the bus with wena.
                    state    <= ACK;
                    mem_ena  <= 1'b0;
                    mem_wena <= 1'b0;
                    drv_q    <= 1'b0;
                    ack0     <= (id_q == REQ_ID0);
                    ack1     <= (id_q == REQ_ID1);
                end
                READ: begin
                    // RAM registers the word on this edge and puts it on the bus next.
                    state   <= RDATA;
                    mem_ena <= 1'b0;
                end
                RDATA: begin
                    rdata <= mem_data;
                    state <= ACK;
                    ack0  <= (id_q == REQ_ID0);
                    ack1  <= (id_q == REQ_ID1);
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_ena  <= 1'b0;
                    mem_wena <= 1'b0;
                    drv_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
